pixel_adc_sequencer: RTL and testbench

//  Frame controller for the pixel array: drives erase/expose/ramp strobes into NUM_PIXELS analog pixel

---
 rtl/pixel_adc_pkg.sv | 17 +
 rtl/pixel_adc_sequencer_if.sv | 18 +
 rtl/pixel_code_capture.sv | 37 +++
 rtl/pixel_adc_sequencer.sv | 154 +++++++++++++++
 tb/tb_pixel_adc_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_adc_pkg.sv
// Shared types and default sizes for the pixel ADC frame sequencer.
package pixel_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READOUT
  } state_t;

  localparam int DEF_NUM_PIXELS    = 4;
  localparam int DEF_ADC_BITS      = 8;
  localparam int DEF_ERASE_CYCLES  = 2;
  localparam int DEF_EXPOSE_CYCLES = 16;

endpackage

// File: rtl/pixel_adc_sequencer_if.sv
// Readout stream from the sequencer to the pixel memory path (valid/ready, one beat per pixel).
interface pixel_adc_sequencer_if
  import pixel_adc_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int ADC_BITS   = DEF_ADC_BITS
);
  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  logic                pix_valid;
  logic                pix_ready;
  logic [ADC_BITS-1:0] pix_data;
  logic [IDX_W-1:0]    pix_index;
  logic                pix_last;

  modport master (output pix_valid, pix_data, pix_index, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_index, pix_last, output pix_ready);
endinterface

// File: rtl/pixel_code_capture.sv
// Per-pixel code latch: stores the first ramp step at which cmp is seen high.
// PIXEL_SATURATE_EN: an uncaptured pixel reports full scale instead of 0.
module pixel_code_capture
  import pixel_adc_pkg::*;
#(
  parameter int ADC_BITS = DEF_ADC_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                sample,
  input  logic                cmp_bit,
  input  logic [ADC_BITS-1:0] step,
  output logic [ADC_BITS-1:0] code
);
  logic [ADC_BITS-1:0] code_reg;
  logic                captured_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_reg     <= '0;
      captured_reg <= 1'b0;
    end else if (clear) begin
      code_reg     <= '0;
      captured_reg <= 1'b0;
    end else if (sample && cmp_bit && !captured_reg) begin
      code_reg     <= step;
      captured_reg <= 1'b1;
    end
  end

`ifdef PIXEL_SATURATE_EN
  assign code = captured_reg ? code_reg : '1;
`else
  assign code = code_reg;
`endif
endmodule

// File: rtl/pixel_adc_sequencer.sv
// Frame controller: erase/expose/ramp strobes, single-slope conversion and code readout.
// PIXEL_SATURATE_EN (see pixel_code_capture) selects the code reported by uncaptured pixels.
module pixel_adc_sequencer
  import pixel_adc_pkg::*;
#(
  parameter int NUM_PIXELS    = DEF_NUM_PIXELS,
  parameter int ADC_BITS      = DEF_ADC_BITS,
  parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  erase,
  output logic                  expose,
  output logic                  ramp,
  input  logic [NUM_PIXELS-1:0] cmp,
  output logic                  frame_done,
  pixel_adc_sequencer_if.master pix
);
  localparam int IDX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int PH_MAX = (EXPOSE_CYCLES > ERASE_CYCLES) ? EXPOSE_CYCLES : ERASE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0]  ERASE_LAST  = PH_W'(ERASE_CYCLES - 1);
  localparam logic [PH_W-1:0]  EXPOSE_LAST = PH_W'(EXPOSE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PIXELS - 1);

  state_t              state_reg, state_next;
  logic [PH_W-1:0]     phase_reg, phase_next;
  logic [ADC_BITS:0]   step_reg, step_next, step_inc;
  logic                half_reg, half_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                done_next;
  logic                busy_reg, erase_reg, expose_reg, ramp_reg, valid_reg, done_reg;
  logic                clear, sample;
  logic [ADC_BITS-1:0] code_arr [NUM_PIXELS];

  assign step_inc = step_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    step_next  = step_reg;
    half_next  = half_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ERASE;
          phase_next = '0;
        end
      end
      ST_ERASE: begin
        if (phase_reg == ERASE_LAST) begin
          state_next = ST_EXPOSE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      ST_EXPOSE: begin
        if (phase_reg == EXPOSE_LAST) begin
          state_next = ST_CONVERT;
          phase_next = '0;
          step_next  = '0;
          half_next  = 1'b0;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      ST_CONVERT: begin
        // half_reg=0: ramp pulse cycle; half_reg=1: cmp sample cycle, then advance step
        half_next = ~half_reg;
        if (half_reg) begin
          if (step_inc[ADC_BITS]) begin
            state_next = ST_READOUT;
            step_next  = '0;
            idx_next   = '0;
          end else begin
            step_next = step_inc;
          end
        end
      end
      ST_READOUT: begin
        if (pix.pix_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      phase_reg  <= '0;
      step_reg   <= '0;
      half_reg   <= 1'b0;
      idx_reg    <= '0;
      busy_reg   <= 1'b0;
      erase_reg  <= 1'b0;
      expose_reg <= 1'b0;
      ramp_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      step_reg   <= step_next;
      half_reg   <= half_next;
      idx_reg    <= idx_next;
      busy_reg   <= (state_next != ST_IDLE);
      erase_reg  <= (state_next == ST_ERASE);
      expose_reg <= (state_next == ST_EXPOSE);
      ramp_reg   <= (state_next == ST_CONVERT) && !half_next;
      valid_reg  <= (state_next == ST_READOUT);
      done_reg   <= done_next;
    end
  end

  assign clear  = (state_reg == ST_ERASE);
  assign sample = (state_reg == ST_CONVERT) && half_reg;

  for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
    pixel_code_capture #(.ADC_BITS(ADC_BITS)) u_capture (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .sample  (sample),
      .cmp_bit (cmp[gi]),
      .step    (step_reg[ADC_BITS-1:0]),
      .code    (code_arr[gi])
    );
  end

  assign busy          = busy_reg;
  assign erase         = erase_reg;
  assign expose        = expose_reg;
  assign ramp          = ramp_reg;
  assign frame_done    = done_reg;
  assign pix.pix_valid = valid_reg;
  assign pix.pix_index = idx_reg;
  assign pix.pix_last  = valid_reg && (idx_reg == LAST_IDX);
  assign pix.pix_data  = valid_reg ? code_arr[idx_reg] : '0;
endmodule

// File: tb/tb_pixel_adc_sequencer.sv
// Self-checking bench: table-driven frames, reset abort, and random cmp schedules vs a first-event model.
module tb_pixel_adc_sequencer;
  import pixel_adc_pkg::*;

  localparam int NP    = 4;
  localparam int AB    = 8;
  localparam int NSTEP = 256;
`ifdef PIXEL_SATURATE_EN
  localparam int UNCAP = 255;
`else
  localparam int UNCAP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, erase, expose, ramp, frame_done;
  logic [NP-1:0] cmp = '0;

  pixel_adc_sequencer_if #(.NUM_PIXELS(NP), .ADC_BITS(AB)) pif ();

  pixel_adc_sequencer #(
    .NUM_PIXELS(NP), .ADC_BITS(AB), .ERASE_CYCLES(2), .EXPOSE_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .erase      (erase),
    .expose     (expose),
    .ramp       (ramp),
    .cmp        (cmp),
    .frame_done (frame_done),
    .pix        (pif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int first  [NP];  // cmp high from this step (-1: never)
    int len    [NP];  // steps it stays high (0: until end of ramp)
    int again  [NP];  // extra single-step pulse (-1: none)
    int exp_code [NP];
    int ready_mode;   // 0 always ready, 1 pattern 1,0,0, 2 random
    bit inject;       // pulse start during EXPOSE and READOUT
  } vec_t;

  vec_t           vecs [4];
  logic [NSTEP-1:0] sched [NP];
  int             exp_code [NP];
  int             step_seen = 0;
  int             n_checks = 0;
  int             n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // cmp follows the schedule for the step whose ramp pulse was just seen; held through the sample cycle.
  always @(negedge clk) begin
    if (reset || erase) begin
      cmp = '0;
      step_seen = 0;
    end else if (ramp) begin
      for (int i = 0; i < NP; i++)
        cmp[i] = (step_seen < NSTEP) ? sched[i][step_seen] : 1'b0;
      step_seen++;
    end
  end

  task automatic build(input vec_t v);
    for (int i = 0; i < NP; i++) begin
      sched[i] = '0;
      if (v.first[i] >= 0)
        for (int k = v.first[i]; k < NSTEP; k++)
          if (v.len[i] == 0 || k < v.first[i] + v.len[i]) sched[i][k] = 1'b1;
      if (v.again[i] >= 0) sched[i][v.again[i]] = 1'b1;
    end
  endtask

  function automatic int model_code(input logic [NSTEP-1:0] m);
    for (int k = 0; k < NSTEP; k++)
      if (m[k]) return k;
    return UNCAP;
  endfunction

  task automatic run_frame(input int ready_mode, input bit inject, input string tag);
    int n_erase = 0, n_expose = 0, n_ramp = 0;
    int first_expose = -1, first_ramp = -1, first_valid = -1;
    int beat = 0;
    bit held = 0, rdy;
    int held_data = 0, held_idx = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      start = inject && (c == 5);
      if (pif.pix_valid) begin
        first_valid = c;
        break;
      end
      if (erase) n_erase++;
      if (expose) begin
        if (first_expose < 0) first_expose = c;
        n_expose++;
      end
      if (ramp) begin
        if (first_ramp < 0) first_ramp = c;
        n_ramp++;
      end
    end
    start = 1'b0;
    if (first_valid < 0) begin
      chk({tag, " valid_timeout"}, 0, 1);
      return;
    end
    chk({tag, " erase_cycles"}, n_erase, 2);
    chk({tag, " expose_start"}, first_expose, 2);
    chk({tag, " expose_cycles"}, n_expose, 16);
    chk({tag, " first_ramp"}, first_ramp, 18);
    chk({tag, " ramp_pulses"}, n_ramp, NSTEP);
    chk({tag, " convert_len"}, first_valid - first_ramp, 2 * NSTEP);
    for (int c = 0; c < 200 && beat < NP; c++) begin
      chk({tag, " valid_in_readout"}, int'(pif.pix_valid), 1);
      if (held) begin
        chk({tag, " stall_data"}, int'(pif.pix_data), held_data);
        chk({tag, " stall_index"}, int'(pif.pix_index), held_idx);
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pif.pix_ready = rdy;
      start = inject && (c == 1);
      if (rdy) begin
        chk({tag, " data"}, int'(pif.pix_data), exp_code[beat]);
        chk({tag, " index"}, int'(pif.pix_index), beat);
        chk({tag, " last"}, int'(pif.pix_last), int'(beat == NP - 1));
        $display("%s beat idx=%0d data=%0d last=%0d", tag, pif.pix_index, pif.pix_data, pif.pix_last);
        beat++;
        held = 0;
      end else begin
        held = 1;
        held_data = int'(pif.pix_data);
        held_idx = int'(pif.pix_index);
      end
      @(negedge clk);
    end
    pif.pix_ready = 1'b0;
    start = 1'b0;
    chk({tag, " beats"}, beat, NP);
    chk({tag, " valid_drop"}, int'(pif.pix_valid), 0);
    chk({tag, " frame_done"}, int'(frame_done), 1);
    @(negedge clk);
    chk({tag, " frame_done_pulse"}, int'(frame_done), 0);
    repeat (4) begin
      chk({tag, " idle_after"}, int'(busy), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t rv;
    int   nr;
    vecs[0] = '{'{0, 37, 200, 255}, '{0, 0, 0, 0}, '{-1, -1, -1, -1},
                '{0, 37, 200, 255}, 0, 1'b0};
    vecs[1] = '{'{5, 10, -1, 3}, '{0, 1, 0, 1}, '{-1, 50, -1, -1},
                '{5, 10, UNCAP, 3}, 1, 1'b1};
    vecs[2] = '{'{-1, -1, -1, -1}, '{0, 0, 0, 0}, '{-1, -1, -1, -1},
                '{UNCAP, UNCAP, UNCAP, UNCAP}, 1, 1'b0};
    vecs[3] = '{'{200, 128, 128, 128}, '{0, 1, 1, 0}, '{20, -1, -1, -1},
                '{20, 128, 128, 128}, 2, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    pif.pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset erase", int'(erase), 0);
    chk("reset expose", int'(expose), 0);
    chk("reset ramp", int'(ramp), 0);
    chk("reset valid", int'(pif.pix_valid), 0);
    chk("reset data", int'(pif.pix_data), 0);
    chk("reset frame_done", int'(frame_done), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      build(vecs[v]);
      for (int i = 0; i < NP; i++) exp_code[i] = vecs[v].exp_code[i];
      run_frame(vecs[v].ready_mode, vecs[v].inject, $sformatf("vec%0d", v));
    end

    // Abort a frame during the ramp pulse of step 100.
    build(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nr = 0;
    for (int c = 0; c < 1000 && nr < 101; c++) begin
      @(negedge clk);
      if (ramp) nr++;
    end
    chk("abort reached step 100", nr, 101);
    reset = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort ramp", int'(ramp), 0);
    chk("abort valid", int'(pif.pix_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("abort frame_done", int'(frame_done), 0);
      chk("abort stays idle", int'(busy), 0);
    end
    build(vecs[1]);
    for (int i = 0; i < NP; i++) exp_code[i] = vecs[1].exp_code[i];
    run_frame(0, 1'b0, "after_abort");

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NP; i++) begin
        nr = int'($urandom_range(0, 300));
        rv.first[i] = (nr > 255) ? -1 : nr;
        rv.len[i] = int'($urandom_range(0, 4));
        nr = int'($urandom_range(0, 400));
        rv.again[i] = (nr > 255) ? -1 : nr;
        rv.exp_code[i] = 0;
      end
      build(rv);
      for (int i = 0; i < NP; i++) exp_code[i] = model_code(sched[i]);
      run_frame(2, 1'b0, $sformatf("rand%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
